id_remap_table: RTL and testbench

Parametrised successor to the single-row-pointer ID allocator: remaps AXI-style original IDs onto unique IDs `{row,col}` for the ROB. Each row is bound to one original ID. Column slots are tracked per row with an occupancy bitmap, so frees may arrive in any order. Allocation and free use valid/ready handshakes, and the restored ID is returned as a registered response. The block sits between the request-side ID mapper and the response-side reorder logic.

---
 rtl/id_remap_pkg.sv | 32 +++
 rtl/id_remap_row.sv | 75 +++++++
 rtl/id_remap_table.sv | 150 +++++++++++++++
 tb/tb_id_remap_table.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_remap_pkg.sv
// Shared types and helpers for the ID remap table.
// Widths here are upper bounds; modules slice down to their parameters.
package id_remap_pkg;

    localparam int MAX_ID_W  = 32;
    localparam int MAX_COLS  = 32;
    localparam int MAX_COL_W = $clog2(MAX_COLS);

    typedef struct packed {
        logic                bound;
        logic [MAX_ID_W-1:0] bound_id;
        logic [MAX_COLS-1:0] occ;
    } row_state_t;

    function automatic int uid_w(input int rows, input int cols);
        return $clog2(rows) + $clog2(cols);
    endfunction

    function automatic int cnt_w(input int rows, input int cols);
        return $clog2(rows * cols + 1);
    endfunction

    function automatic logic [MAX_COL_W-1:0] lowest_clear(
        input logic [MAX_COLS-1:0] v
    );
        lowest_clear = '0;
        for (int i = MAX_COLS - 1; i >= 0; i--) begin
            if (!v[i]) lowest_clear = MAX_COL_W'(i);
        end
    endfunction

endpackage

// File: rtl/id_remap_row.sv
// One bindable row: binding, slot bitmap, per-slot tags,
// hit compare and lowest free column.
module id_remap_row
    import id_remap_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int NUM_COLS = 4,
    parameter int COL_W    = $clog2(NUM_COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc_en,
    input  logic [ID_W-1:0]  i_alloc_id,
    input  logic             i_free_en,
    input  logic [COL_W-1:0] i_free_col,
    output logic             o_hit,
    output logic             o_bound,
    output logic             o_has_free,
    output logic [COL_W-1:0] o_col,
    output logic             o_free_occ,
    output logic [ID_W-1:0]  o_free_tag
);

    localparam logic [MAX_COLS-1:0] COL_MASK =
        {MAX_COLS{1'b1}} >> (MAX_COLS - NUM_COLS);

    row_state_t          r_st;
    logic [ID_W-1:0]     r_tag [NUM_COLS];

    logic [MAX_COLS-1:0]  w_occ_eff;
    logic [MAX_COLS-1:0]  w_set;
    logic [MAX_COLS-1:0]  w_clr;
    logic [MAX_COLS-1:0]  w_occ_nxt;
    logic [MAX_COL_W-1:0] w_col_x;
    logic [MAX_COL_W-1:0] w_fcol_x;

    // Columns beyond NUM_COLS look permanently occupied
    assign w_occ_eff  = r_st.occ | ~COL_MASK;
    assign w_col_x    = lowest_clear(w_occ_eff);
    assign o_col      = COL_W'(w_col_x);
    assign o_has_free = ~&w_occ_eff;
    assign o_bound    = r_st.bound;
    assign o_hit      = r_st.bound &&
        (r_st.bound_id == MAX_ID_W'(i_alloc_id));

    assign w_fcol_x   = MAX_COL_W'(i_free_col);
    assign o_free_occ = r_st.occ[w_fcol_x];
    assign o_free_tag = r_tag[i_free_col];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        w_set[w_col_x]  = i_alloc_en;
        w_clr[w_fcol_x] = i_free_en;
        w_occ_nxt = ((r_st.occ & ~w_clr) | w_set) & COL_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st <= '0;
            for (int c = 0; c < NUM_COLS; c++) r_tag[c] <= '0;
        end else begin
            r_st.occ <= w_occ_nxt;
            if (i_alloc_en) begin
                r_tag[o_col] <= i_alloc_id;
                r_st.bound   <= 1'b1;
                if (!r_st.bound)
                    r_st.bound_id <= MAX_ID_W'(i_alloc_id);
            end else if (i_free_en && w_occ_nxt == '0) begin
                r_st.bound <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/id_remap_table.sv
// Remaps original IDs onto unique {row,col} IDs for the ROB.
// Optional illegal-free detection: ID_REMAP_ERR_CHECK_EN.
module id_remap_table
    import id_remap_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    localparam int CNT_W   = cnt_w(NUM_ROWS, NUM_COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [ID_W-1:0]  alloc_orig_id,
    output logic             alloc_ready,
    output logic [ID_W-1:0]  alloc_uid,
    input  logic             free_valid,
    input  logic [ID_W-1:0]  free_uid,
    output logic             free_ready,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_orig_id,
    output logic [ID_W-1:0]  rsp_uid,
    output logic [CNT_W-1:0] outstanding,
    output logic             full,
    output logic             err_free_unalloc
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int UID_W = ROW_W + COL_W;
    localparam int TOTAL = NUM_ROWS * NUM_COLS;

    if (UID_W > ID_W) begin : g_bad_uid
        $error("UID_W exceeds ID_W");
    end
    if (NUM_COLS > MAX_COLS || ID_W > MAX_ID_W) begin : g_bad_max
        $error("parameters exceed package limits");
    end

    logic [NUM_ROWS-1:0] w_hit, w_bound, w_has_free;
    logic [NUM_ROWS-1:0] w_alloc_en, w_free_en, w_free_occ;
    logic [COL_W-1:0]    w_col      [NUM_ROWS];
    logic [ID_W-1:0]     w_free_tag [NUM_ROWS];

    logic             w_any_hit, w_any_unb;
    logic [ROW_W-1:0] w_hit_row, w_unb_row, w_row, w_free_row;
    logic [COL_W-1:0] w_free_col;
    logic             w_alloc_fire, w_free_hit, w_free_do;

    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_orig, r_rsp_uid;

    assign w_free_row = free_uid[UID_W-1:COL_W];
    assign w_free_col = free_uid[COL_W-1:0];

    always_comb begin
        w_any_hit = 1'b0;
        w_hit_row = '0;
        w_any_unb = 1'b0;
        w_unb_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (w_hit[r]) begin
                w_any_hit = 1'b1;
                w_hit_row = ROW_W'(r);
            end
            if (!w_bound[r]) begin
                w_any_unb = 1'b1;
                w_unb_row = ROW_W'(r);
            end
        end
    end

    // A full hit row stalls rather than binding a second row
    assign w_row        = w_any_hit ? w_hit_row : w_unb_row;
    assign alloc_ready  = w_any_hit ? w_has_free[w_hit_row]
                                    : w_any_unb;
    assign alloc_uid    = ID_W'({w_row, w_col[w_row]});
    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign w_free_hit   = w_free_occ[w_free_row];

`ifdef ID_REMAP_ERR_CHECK_EN
    assign w_free_do = free_valid & w_free_hit;
`else
    assign w_free_do = free_valid;
`endif

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        assign w_alloc_en[r] = w_alloc_fire &&
            (w_row == ROW_W'(r));
        assign w_free_en[r]  = w_free_do &&
            (w_free_row == ROW_W'(r));

        id_remap_row #(
            .ID_W     (ID_W),
            .NUM_COLS (NUM_COLS),
            .COL_W    (COL_W)
        ) u_row (
            .clk        (clk),
            .rst        (rst),
            .i_alloc_en (w_alloc_en[r]),
            .i_alloc_id (alloc_orig_id),
            .i_free_en  (w_free_en[r]),
            .i_free_col (w_free_col),
            .o_hit      (w_hit[r]),
            .o_bound    (w_bound[r]),
            .o_has_free (w_has_free[r]),
            .o_col      (w_col[r]),
            .o_free_occ (w_free_occ[r]),
            .o_free_tag (w_free_tag[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_orig  <= '0;
            r_rsp_uid   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(w_alloc_fire)
                           - CNT_W'(w_free_do);
            r_rsp_valid <= free_valid;
            if (free_valid) begin
                r_rsp_orig <= w_free_hit ?
                    w_free_tag[w_free_row] : '0;
                r_rsp_uid  <= free_uid;
            end
        end
    end

`ifdef ID_REMAP_ERR_CHECK_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if (free_valid && !w_free_hit) r_err <= 1'b1;
    end
    assign err_free_unalloc = r_err;
`else
    assign err_free_unalloc = 1'b0;
`endif

    assign free_ready  = 1'b1;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_orig_id = r_rsp_orig;
    assign rsp_uid     = r_rsp_uid;
    assign outstanding = r_cnt;
    assign full        = (r_cnt == CNT_W'(TOTAL));

endmodule

// File: tb/tb_id_remap_table.sv
// Scoreboard bench for id_remap_table: directed vectors,
// grants and responses checked by a negedge monitor.
module tb_id_remap_table;

    localparam int ID_W  = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_valid = 1'b0;
    logic [ID_W-1:0]  alloc_orig_id = '0;
    logic             alloc_ready;
    logic [ID_W-1:0]  alloc_uid;
    logic             free_valid = 1'b0;
    logic [ID_W-1:0]  free_uid = '0;
    logic             free_ready;
    logic             rsp_valid;
    logic [ID_W-1:0]  rsp_orig_id;
    logic [ID_W-1:0]  rsp_uid;
    logic [CNT_W-1:0] outstanding;
    logic             full;
    logic             err_free_unalloc;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_alloc_q [$];
    logic [7:0] exp_rsp_q   [$];

    always #5 clk = ~clk;

    id_remap_table #(
        .ID_W     (4),
        .NUM_ROWS (4),
        .NUM_COLS (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_orig_id    (alloc_orig_id),
        .alloc_ready      (alloc_ready),
        .alloc_uid        (alloc_uid),
        .free_valid       (free_valid),
        .free_uid         (free_uid),
        .free_ready       (free_ready),
        .rsp_valid        (rsp_valid),
        .rsp_orig_id      (rsp_orig_id),
        .rsp_uid          (rsp_uid),
        .outstanding      (outstanding),
        .full             (full),
        .err_free_unalloc (err_free_unalloc)
    );

    task automatic chk(input string name, input int act,
                       input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents output
    always @(negedge clk) begin
        if (!rst) begin
            if (alloc_valid && alloc_ready) begin
                if (exp_alloc_q.size() == 0) begin
                    chk("unexpected_grant", int'(alloc_uid), -1);
                end else begin
                    logic [3:0] e;
                    e = exp_alloc_q.pop_front();
                    chk("alloc_uid", int'(alloc_uid), int'(e));
                end
            end
            if (rsp_valid) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_rsp", int'(rsp_uid), -1);
                end else begin
                    logic [7:0] r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_orig_id", int'(rsp_orig_id),
                        int'(r[7:4]));
                    chk("rsp_uid", int'(rsp_uid), int'(r[3:0]));
                end
            end
        end
    end

    task automatic cyc(input bit av, input logic [3:0] aid,
                       input bit fv, input logic [3:0] fu);
        alloc_valid   = av;
        alloc_orig_id = aid;
        free_valid    = fv;
        free_uid      = fu;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 4'h0);
    endtask

    task automatic alloc(input logic [3:0] id,
                         input logic [3:0] uid);
        exp_alloc_q.push_back(uid);
        cyc(1, id, 0, 4'h0);
    endtask

    task automatic free(input logic [3:0] uid,
                        input logic [3:0] orig);
        exp_rsp_q.push_back({orig, uid});
        cyc(0, 4'h0, 1, uid);
    endtask

    task automatic stall(input string name,
                         input logic [3:0] id);
        alloc_valid   = 1'b1;
        alloc_orig_id = id;
        #1;
        chk(name, int'(alloc_ready), 0);
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_alloc_ready", int'(alloc_ready), 1);
        chk("rst_alloc_uid", int'(alloc_uid), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_orig", int'(rsp_orig_id), 0);
        chk("rst_rsp_uid", int'(rsp_uid), 0);
        chk("rst_outstanding", int'(outstanding), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_err", int'(err_free_unalloc), 0);
        chk("free_ready", int'(free_ready), 1);

        // Same ID fills one row in column order
        alloc(4'h5, 4'h0);
        alloc(4'h5, 4'h1);
        alloc(4'h5, 4'h2);
        chk("out_after_3", int'(outstanding), 3);

        // Out-of-order free and slot reuse
        free(4'h1, 4'h5);
        chk("out_after_free", int'(outstanding), 2);
        alloc(4'h5, 4'h1);
        chk("out_after_reuse", int'(outstanding), 3);

        // Hit row full stalls; new ID binds the next row
        do_reset();
        for (int k = 0; k < 4; k++) alloc(4'h3, 4'(k));
        stall("ready_row_full", 4'h3);
        alloc(4'h9, 4'h4);
        chk("out_after_stall", int'(outstanding), 5);

        // Free and alloc together on the same row
        do_reset();
        alloc(4'h7, 4'h0);
        exp_alloc_q.push_back(4'h1);
        exp_rsp_q.push_back({4'h7, 4'h0});
        cyc(1, 4'h7, 1, 4'h0);
        chk("out_simul", int'(outstanding), 1);
        alloc(4'h8, 4'h4);
        chk("out_after_simul", int'(outstanding), 2);

        // Fill every slot
        do_reset();
        for (int id = 0; id < 4; id++)
            for (int k = 0; k < 4; k++)
                alloc(4'(id), 4'(id * 4 + k));
        chk("full_set", int'(full), 1);
        chk("out_full", int'(outstanding), 16);
        stall("ready_full_new", 4'hA);
        stall("ready_full_hit", 4'h0);
        free(4'h9, 4'h2);
        chk("full_clear", int'(full), 0);
        chk("out_15", int'(outstanding), 15);
        stall("ready_no_unbound", 4'hA);
        alloc(4'h2, 4'h9);
        chk("full_again", int'(full), 1);

        // Free of a slot that was never allocated
        do_reset();
        alloc(4'h5, 4'h0);
        free(4'h6, 4'h0);
`ifdef ID_REMAP_ERR_CHECK_EN
        chk("err_set", int'(err_free_unalloc), 1);
        chk("out_illegal", int'(outstanding), 1);
        idle(3);
        chk("err_sticky", int'(err_free_unalloc), 1);
        free(4'h0, 4'h5);
        chk("err_sticky2", int'(err_free_unalloc), 1);
        chk("out_legal", int'(outstanding), 0);
`else
        chk("err_tied", int'(err_free_unalloc), 0);
        chk("out_nocheck", int'(outstanding), 0);
`endif

        idle(3);
        chk("alloc_q_drained", exp_alloc_q.size(), 0);
        chk("rsp_q_drained", exp_rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
